checkpoint_alloc: RTL and testbench

- Allocator for the branch-checkpoint pool shared by the in-order front end (fetch/decode slots) and released by commit.
- Grants checkpoint IDs to up to ALLOC_WIDTH requesting slots per cycle, in strict slot order.
- Reclaims IDs from commit via FREE_WIDTH free ports, and reclaims every ID on a commit flush.
- Its grants feed the checkpoint_id_valid / checkpoint_id fields of fetch_decode_pack_t.

---
 rtl/checkpoint_alloc.sv | 103 ++++++++++
 tb/tb_checkpoint_alloc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_alloc.sv
// checkpoint_alloc: in-order branch-checkpoint ID allocator with commit free ports, flush reclaim and sticky double-free detection
module checkpoint_alloc #(
    parameter int CHECKPOINT_NUM = 16,
    parameter int ALLOC_WIDTH    = 2,
    parameter int FREE_WIDTH     = 2,
    parameter int ID_W           = $clog2(CHECKPOINT_NUM),
    parameter int CNT_W          = $clog2(CHECKPOINT_NUM + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ALLOC_WIDTH-1:0]      alloc_req,
    output logic [ALLOC_WIDTH-1:0]      alloc_grant,
    output logic [ALLOC_WIDTH*ID_W-1:0] alloc_id,
    input  logic [FREE_WIDTH-1:0]       free_valid,
    input  logic [FREE_WIDTH*ID_W-1:0]  free_id,
    input  logic                        flush,
    output logic [CNT_W-1:0]            free_count,
    output logic                        full,
    output logic                        idle,
    output logic                        double_free_err
);
    logic [CHECKPOINT_NUM-1:0] free_map_q, free_map_d, avail;
    logic [CNT_W-1:0]          free_count_q, free_count_d;
    logic                      err_q, err_d, ok, found, dup;
    logic [ID_W-1:0]           pick;
    logic [ALLOC_WIDTH-1:0]    grant;
    logic [ALLOC_WIDTH*ID_W-1:0] ids;

    always_comb begin
        avail = free_map_q;
        ok = !rst && !flush;
        grant = '0;
        ids = '0;
        found = 1'b0;
        pick = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            found = 1'b0;
            pick = '0;
            for (int k = CHECKPOINT_NUM - 1; k >= 0; k--) begin
                if (avail[k]) begin
                    found = 1'b1;
                    pick = ID_W'(k);
                end
            end
            if (alloc_req[i]) begin
                ok = ok && found;
                grant[i] = ok;
                ids[i*ID_W +: ID_W] = ok ? pick : '0;
                if (ok) avail[pick] = 1'b0;
            end
        end
    end

    always_comb begin
        free_map_d = free_map_q;
        free_count_d = free_count_q;
        err_d = err_q;
        dup = 1'b0;
        if (flush) begin
            free_map_d = '1;
            free_count_d = CNT_W'(CHECKPOINT_NUM);
        end else begin
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
                if (grant[i]) begin
                    free_map_d[ids[i*ID_W +: ID_W]] = 1'b0;
                    free_count_d = free_count_d - CNT_W'(1);
                end
            end
            for (int p = 0; p < FREE_WIDTH; p++) begin
                dup = 1'b0;
                for (int q = 0; q < p; q++)
                    dup = dup || (free_valid[q] && free_id[q*ID_W +: ID_W] == free_id[p*ID_W +: ID_W]);
                if (free_valid[p]) begin
                    if (free_map_q[free_id[p*ID_W +: ID_W]] || dup) begin
                        err_d = 1'b1;
                    end else begin
                        free_map_d[free_id[p*ID_W +: ID_W]] = 1'b1;
                        free_count_d = free_count_d + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_map_q <= '1;
            free_count_q <= CNT_W'(CHECKPOINT_NUM);
            err_q <= 1'b0;
        end else begin
            free_map_q <= free_map_d;
            free_count_q <= free_count_d;
            err_q <= err_d;
        end
    end

    assign alloc_grant = grant;
    assign alloc_id = ids;
    assign free_count = free_count_q;
    assign full = free_count_q == '0;
    assign idle = free_count_q == CNT_W'(CHECKPOINT_NUM);
    assign double_free_err = err_q;
endmodule

// File: tb/tb_checkpoint_alloc.sv
// tb_checkpoint_alloc: table-driven and randomized checks of checkpoint_alloc against a free-set model
module tb_checkpoint_alloc;
    logic       clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [1:0] alloc_req = '0, alloc_grant, free_valid = '0;
    logic [7:0] alloc_id, free_id = '0;
    logic [4:0] free_count;
    logic       full, idle, double_free_err;

    checkpoint_alloc dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_grant(alloc_grant),
        .alloc_id(alloc_id), .free_valid(free_valid), .free_id(free_id), .flush(flush),
        .free_count(free_count), .full(full), .idle(idle), .double_free_err(double_free_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit mfree[16];
    int mcnt;
    bit merr;
    logic [1:0] g_s;
    logic [3:0] i0_s, i1_s;

    typedef struct {
        logic [1:0] req, fv;
        logic [3:0] f0, f1;
        logic       fl;
        logic [1:0] g;
        logic [3:0] i0, i1;
        int         cnt;
        logic       err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mreset();
        for (int k = 0; k < 16; k++) mfree[k] = 1'b1;
        mcnt = 16;
        merr = 1'b0;
    endfunction

    function automatic void mgrant(input logic [1:0] req, input logic fl,
                                   output logic [1:0] g, output logic [3:0] i0, output logic [3:0] i1);
        int q[$];
        int n;
        bit stop;
        g = '0; i0 = '0; i1 = '0; n = 0; stop = 1'b0;
        for (int k = 0; k < 16; k++) if (mfree[k]) q.push_back(k);
        if (!fl) begin
            for (int s = 0; s < 2; s++) begin
                if (req[s] && !stop) begin
                    if (n < q.size()) begin
                        g[s] = 1'b1;
                        if (s == 0) i0 = 4'(q[n]); else i1 = 4'(q[n]);
                        n++;
                    end else stop = 1'b1;
                end
            end
        end
    endfunction

    function automatic void mupdate(input logic [1:0] g, input logic [3:0] i0, input logic [3:0] i1,
                                    input logic [1:0] fv, input logic [3:0] f0, input logic [3:0] f1,
                                    input logic fl);
        bit old[16];
        if (fl) begin
            for (int k = 0; k < 16; k++) mfree[k] = 1'b1;
        end else begin
            old = mfree;
            if (g[0]) mfree[i0] = 1'b0;
            if (g[1]) mfree[i1] = 1'b0;
            if (fv[0]) begin
                if (old[f0]) merr = 1'b1; else mfree[f0] = 1'b1;
            end
            if (fv[1]) begin
                if (old[f1] || (fv[0] && f0 == f1)) merr = 1'b1; else mfree[f1] = 1'b1;
            end
        end
        mcnt = 0;
        for (int k = 0; k < 16; k++) mcnt += int'(mfree[k]);
    endfunction

    task automatic step(input logic [1:0] req, input logic [1:0] fv, input logic [3:0] f0,
                        input logic [3:0] f1, input logic fl);
        logic [1:0] eg;
        logic [3:0] e0, e1;
        alloc_req = req; free_valid = fv; free_id = {f1, f0}; flush = fl;
        #1;
        mgrant(req, fl, eg, e0, e1);
        g_s = alloc_grant; i0_s = alloc_id[3:0]; i1_s = alloc_id[7:4];
        chk("grant", int'(g_s), int'(eg));
        chk("id0", int'(i0_s), int'(e0));
        chk("id1", int'(i1_s), int'(e1));
        @(posedge clk);
        mupdate(eg, e0, e1, fv, f0, f1, fl);
        #1;
        chk("free_count", int'(free_count), mcnt);
        chk("full", int'(full), int'(mcnt == 0));
        chk("idle", int'(idle), int'(mcnt == 16));
        chk("double_free_err", int'(double_free_err), int'(merr));
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] fv, input logic [3:0] f0,
                                input logic [3:0] f1, input logic fl, input logic [1:0] g,
                                input logic [3:0] i0, input logic [3:0] i1, input int cnt, input logic err);
        vec_t v;
        v.req = req; v.fv = fv; v.f0 = f0; v.f1 = f1; v.fl = fl;
        v.g = g; v.i0 = i0; v.i1 = i1; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    initial begin
        tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 2'b11, 0, 1, 14, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 0, 0, 2'b00, 0, 0, 15, 0));
        tbl.push_back(mk(2'b10, 2'b00, 0, 0, 0, 2'b10, 0, 1, 14, 0));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 2'b11, 4'(2 + 2 * k), 4'(3 + 2 * k), 12 - 2 * k, 0));
        tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 2'b01, 14, 0, 1, 0));
        tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 2'b01, 15, 0, 0, 0));
        tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 2'b01, 5, 0, 0, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 2'b01, 5, 0, 0, 0));
        tbl.push_back(mk(2'b00, 2'b11, 0, 1, 0, 2'b00, 0, 0, 2, 0));
        tbl.push_back(mk(2'b00, 2'b11, 2, 3, 0, 2'b00, 0, 0, 4, 0));
        tbl.push_back(mk(2'b00, 2'b11, 4, 5, 0, 2'b00, 0, 0, 6, 0));
        tbl.push_back(mk(2'b11, 2'b01, 6, 0, 1, 2'b00, 0, 0, 16, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 2'b11, 4'(2 * k), 4'(2 * k + 1), 14 - 2 * k, 0));
        tbl.push_back(mk(2'b00, 2'b01, 9, 0, 0, 2'b00, 0, 0, 8, 1));
        tbl.push_back(mk(2'b00, 2'b11, 7, 7, 0, 2'b00, 0, 0, 9, 1));
        tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 2'b01, 7, 0, 8, 1));

        mreset();
        repeat (2) @(negedge clk);
        alloc_req = 2'b11;
        #1;
        chk("grant_in_reset", int'(alloc_grant), 0);
        chk("id_in_reset", int'(alloc_id), 0);
        alloc_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_count", int'(free_count), 16);
        chk("reset_full", int'(full), 0);
        chk("reset_idle", int'(idle), 1);
        chk("reset_err", int'(double_free_err), 0);
        @(negedge clk);

        foreach (tbl[n]) begin
            step(tbl[n].req, tbl[n].fv, tbl[n].f0, tbl[n].f1, tbl[n].fl);
            chk($sformatf("vec%0d_grant", n), int'(g_s), int'(tbl[n].g));
            chk($sformatf("vec%0d_id0", n), int'(i0_s), int'(tbl[n].i0));
            chk($sformatf("vec%0d_id1", n), int'(i1_s), int'(tbl[n].i1));
            chk($sformatf("vec%0d_count", n), int'(free_count), tbl[n].cnt);
            chk($sformatf("vec%0d_err", n), int'(double_free_err), int'(tbl[n].err));
        end

        alloc_req = 2'b11; free_valid = '0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_grant", int'(alloc_grant), 0);
        chk("async_rst_count", int'(free_count), 16);
        chk("async_rst_idle", int'(idle), 1);
        chk("async_rst_err", int'(double_free_err), 0);
        @(negedge clk);
        rst = 1'b0;
        alloc_req = '0;
        mreset();
        @(negedge clk);

        for (int n = 0; n < 400; n++)
            step(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 19) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
